// File: rtl/wbu.sv
// wbu: writeback unit between EXU/LSU and the GPR file.
// Accepts completed instructions from EXU over a valid/ready handshake, waits
// for the LSU read response on loads, extracts and extends the addressed lane,
// and issues one registered single-cycle register write plus a commit pulse
// per instruction.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   exu_*                    completed-instruction handshake and payload
//   lsu_rvalid_i/rready_o    LSU read response handshake (rdata_i, rerr_i)
//   reg_we_o/waddr_o/wdata_o GPR write port
//   commit_o, err_o          retire pulse and error pulse (with commit_o)
//   wb_busy_o, wb_rd_o       held-instruction status for RAW stalls
module wbu #(
  parameter int unsigned XLEN    = 64,
  parameter int unsigned RADDR_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               exu_valid_i,
  output logic               exu_ready_o,
  input  logic [RADDR_W-1:0] exu_rd_i,
  input  logic               exu_rd_we_i,
  input  logic [XLEN-1:0]    exu_result_i,
  input  logic               exu_is_load_i,
  input  logic [1:0]         exu_load_size_i,
  input  logic               exu_load_unsigned_i,
  input  logic [2:0]         exu_addr_lo_i,
  input  logic               lsu_rvalid_i,
  output logic               lsu_rready_o,
  input  logic [XLEN-1:0]    lsu_rdata_i,
  input  logic               lsu_rerr_i,
  output logic               reg_we_o,
  output logic [RADDR_W-1:0] reg_waddr_o,
  output logic [XLEN-1:0]    reg_wdata_o,
  output logic               commit_o,
  output logic               err_o,
  output logic               wb_busy_o,
  output logic [RADDR_W-1:0] wb_rd_o
);

  typedef enum logic [1:0] {IDLE, WAIT_MEM, WRITE} state_t;

  state_t             state;
  logic [RADDR_W-1:0] rd_q;
  logic               rd_we_q;
  logic [1:0]         size_q;
  logic               uns_q;
  logic [2:0]         addr_q;

  logic               accept;
  logic               misaligned;
  logic [XLEN-1:0]    shifted;
  logic [XLEN-1:0]    load_data;

  assign exu_ready_o  = ~rst & (state != WAIT_MEM);
  assign lsu_rready_o = ~rst & (state == WAIT_MEM);
  assign accept       = exu_valid_i & exu_ready_o;
  assign wb_busy_o    = (state != IDLE);

  always_comb begin
    misaligned = 1'b0;
    case (exu_load_size_i)
      2'd1:    misaligned = exu_addr_lo_i[0];
      2'd2:    misaligned = |exu_addr_lo_i[1:0];
      2'd3:    misaligned = |exu_addr_lo_i;
      default: misaligned = 1'b0;
    endcase
  end

  // Lane select by shifting the addressed byte down to bit 0, then extend.
  always_comb begin
    shifted   = lsu_rdata_i >> {addr_q, 3'b000};
    load_data = shifted;
    case (size_q)
      2'd0: load_data = uns_q ? {{(XLEN-8){1'b0}}, shifted[7:0]}
                              : {{(XLEN-8){shifted[7]}}, shifted[7:0]};
      2'd1: load_data = uns_q ? {{(XLEN-16){1'b0}}, shifted[15:0]}
                              : {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      2'd2: load_data = uns_q ? {{(XLEN-32){1'b0}}, shifted[31:0]}
                              : {{(XLEN-32){shifted[31]}}, shifted[31:0]};
      default: load_data = shifted;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      reg_we_o    <= 1'b0;
      reg_waddr_o <= '0;
      reg_wdata_o <= '0;
      commit_o    <= 1'b0;
      err_o       <= 1'b0;
      wb_rd_o     <= '0;
      rd_q        <= '0;
      rd_we_q     <= 1'b0;
      size_q      <= '0;
      uns_q       <= 1'b0;
      addr_q      <= '0;
    end else begin
      reg_we_o <= 1'b0;
      commit_o <= 1'b0;
      err_o    <= 1'b0;
      if (state == WAIT_MEM) begin
        if (lsu_rvalid_i) begin
          state       <= WRITE;
          reg_we_o    <= rd_we_q & (rd_q != '0) & ~lsu_rerr_i;
          reg_waddr_o <= rd_q;
          reg_wdata_o <= load_data;
          commit_o    <= 1'b1;
          err_o       <= lsu_rerr_i;
        end
      end else if (accept) begin
        rd_q    <= exu_rd_i;
        rd_we_q <= exu_rd_we_i;
        size_q  <= exu_load_size_i;
        uns_q   <= exu_load_unsigned_i;
        addr_q  <= exu_addr_lo_i;
        wb_rd_o <= exu_rd_we_i ? exu_rd_i : '0;
        if (exu_is_load_i & ~misaligned) begin
          state <= WAIT_MEM;
        end else begin
          // Non-loads and misaligned loads write back straight from the
          // accept edge; a load reaching here is always misaligned.
          state       <= WRITE;
          reg_we_o    <= exu_rd_we_i & (exu_rd_i != '0) & ~exu_is_load_i;
          reg_waddr_o <= exu_rd_i;
          reg_wdata_o <= exu_result_i;
          commit_o    <= 1'b1;
          err_o       <= exu_is_load_i;
        end
      end else begin
        state <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_wbu.sv
module tb_wbu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        exu_valid_i = 1'b0;
  logic        exu_ready_o;
  logic [4:0]  exu_rd_i = '0;
  logic        exu_rd_we_i = 1'b0;
  logic [63:0] exu_result_i = '0;
  logic        exu_is_load_i = 1'b0;
  logic [1:0]  exu_load_size_i = '0;
  logic        exu_load_unsigned_i = 1'b0;
  logic [2:0]  exu_addr_lo_i = '0;
  logic        lsu_rvalid_i = 1'b0;
  logic        lsu_rready_o;
  logic [63:0] lsu_rdata_i = '0;
  logic        lsu_rerr_i = 1'b0;
  logic        reg_we_o;
  logic [4:0]  reg_waddr_o;
  logic [63:0] reg_wdata_o;
  logic        commit_o;
  logic        err_o;
  logic        wb_busy_o;
  logic [4:0]  wb_rd_o;

  wbu #(.XLEN(64), .RADDR_W(5)) dut (
    .clk(clk), .rst(rst),
    .exu_valid_i(exu_valid_i), .exu_ready_o(exu_ready_o),
    .exu_rd_i(exu_rd_i), .exu_rd_we_i(exu_rd_we_i),
    .exu_result_i(exu_result_i), .exu_is_load_i(exu_is_load_i),
    .exu_load_size_i(exu_load_size_i), .exu_load_unsigned_i(exu_load_unsigned_i),
    .exu_addr_lo_i(exu_addr_lo_i),
    .lsu_rvalid_i(lsu_rvalid_i), .lsu_rready_o(lsu_rready_o),
    .lsu_rdata_i(lsu_rdata_i), .lsu_rerr_i(lsu_rerr_i),
    .reg_we_o(reg_we_o), .reg_waddr_o(reg_waddr_o), .reg_wdata_o(reg_wdata_o),
    .commit_o(commit_o), .err_o(err_o),
    .wb_busy_o(wb_busy_o), .wb_rd_o(wb_rd_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic        rd_we;
    logic [63:0] res;
    logic        ld;
    logic [1:0]  sz;
    logic        uns;
    logic [2:0]  a;
    logic [63:0] rdata;
    logic        rerr;
    int          dly;
    logic        hs;      // expect an LSU handshake
    logic        e_we;
    logic [63:0] e_data;
    logic        e_err;
  } vec_t;

  typedef struct {
    logic        we;
    logic [4:0]  waddr;
    logic [63:0] wdata;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t sbq[$];
  vec_t vecs[15];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Output monitor: pops the scoreboard on every commit pulse.
  always @(negedge clk) begin
    exp_t e;
    if (commit_o) begin
      if (sbq.size() == 0) begin
        chk("unexpected_commit", 64'(commit_o), 64'd0);
      end else begin
        e = sbq.pop_front();
        chk("commit_cycle", 64'(cyc), 64'(e.cyc));
        chk("reg_we", 64'(reg_we_o), 64'(e.we));
        chk("err", 64'(err_o), 64'(e.err));
        if (e.we) begin
          chk("waddr", 64'(reg_waddr_o), 64'(e.waddr));
          chk("wdata", reg_wdata_o, e.wdata);
        end
      end
    end else begin
      chk("idle_we", 64'(reg_we_o), 64'd0);
      chk("idle_err", 64'(err_o), 64'd0);
    end
    cyc++;
  end

  // Present an instruction and hold it until accepted; returns just after the accept edge.
  task automatic issue(input vec_t v);
    bit ok = 1'b0;
    exu_valid_i = 1'b1;
    exu_rd_i = v.rd; exu_rd_we_i = v.rd_we; exu_result_i = v.res;
    exu_is_load_i = v.ld; exu_load_size_i = v.sz;
    exu_load_unsigned_i = v.uns; exu_addr_lo_i = v.a;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (exu_ready_o) begin ok = 1'b1; break; end
    end
    if (!ok) chk("exu_ready_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    exu_valid_i = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    exp_t e;
    bit ok = 1'b0;
    issue(v);
    e.we = v.e_we; e.waddr = v.rd; e.wdata = v.e_data; e.err = v.e_err;
    if (v.hs) begin
      for (int d = 0; d < v.dly; d++) begin
        @(negedge clk);
        chk("wait_exu_ready", 64'(exu_ready_o), 64'd0);
        chk("wait_lsu_rready", 64'(lsu_rready_o), 64'd1);
        chk("wait_busy", 64'(wb_busy_o), 64'd1);
        chk("wait_wb_rd", 64'(wb_rd_o), v.rd_we ? 64'(v.rd) : 64'd0);
        @(posedge clk); #1;
      end
      lsu_rvalid_i = 1'b1; lsu_rdata_i = v.rdata; lsu_rerr_i = v.rerr;
      for (int n = 0; n < 50; n++) begin
        @(negedge clk);
        if (lsu_rready_o) begin ok = 1'b1; break; end
      end
      if (!ok) chk("lsu_rready_timeout", 64'd0, 64'd1);
      @(posedge clk); #1;
      lsu_rvalid_i = 1'b0; lsu_rerr_i = 1'b0;
    end
    e.cyc = cyc;
    sbq.push_back(e);
  endtask

  initial begin
    exp_t e;
    vecs[0]  = '{5'd5, 1'b1, 64'h1234_5678_9ABC_DEF0, 1'b0, 2'd0, 1'b0, 3'd0, 64'd0, 1'b0, 0, 1'b0, 1'b1, 64'h1234_5678_9ABC_DEF0, 1'b0};
    vecs[1]  = '{5'd10, 1'b1, 64'd0, 1'b1, 2'd0, 1'b0, 3'd3, 64'h0000_0000_8000_0000, 1'b0, 4, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FF80, 1'b0};
    vecs[2]  = '{5'd11, 1'b1, 64'd0, 1'b1, 2'd0, 1'b1, 3'd3, 64'h0000_0000_8000_0000, 1'b0, 1, 1'b1, 1'b1, 64'h0000_0000_0000_0080, 1'b0};
    vecs[3]  = '{5'd12, 1'b1, 64'd0, 1'b1, 2'd2, 1'b1, 3'd4, 64'hDEAD_BEEF_0000_0001, 1'b0, 2, 1'b1, 1'b1, 64'h0000_0000_DEAD_BEEF, 1'b0};
    vecs[4]  = '{5'd6, 1'b1, 64'd0, 1'b1, 2'd1, 1'b0, 3'd1, 64'd0, 1'b0, 0, 1'b0, 1'b0, 64'd0, 1'b1};
    vecs[5]  = '{5'd8, 1'b1, 64'd0, 1'b1, 2'd3, 1'b0, 3'd0, 64'h5555_5555_5555_5555, 1'b1, 1, 1'b1, 1'b0, 64'd0, 1'b1};
    vecs[6]  = '{5'd7, 1'b1, 64'h2A, 1'b0, 2'd0, 1'b0, 3'd0, 64'd0, 1'b0, 0, 1'b0, 1'b1, 64'h2A, 1'b0};
    vecs[7]  = '{5'd13, 1'b1, 64'd0, 1'b1, 2'd1, 1'b0, 3'd6, 64'h8001_0000_0000_0000, 1'b0, 0, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_8001, 1'b0};
    vecs[8]  = '{5'd14, 1'b1, 64'd0, 1'b1, 2'd3, 1'b1, 3'd0, 64'hFEDC_BA98_7654_3210, 1'b0, 1, 1'b1, 1'b1, 64'hFEDC_BA98_7654_3210, 1'b0};
    vecs[9]  = '{5'd15, 1'b1, 64'd0, 1'b1, 2'd2, 1'b0, 3'd0, 64'h0000_0000_8765_4321, 1'b0, 0, 1'b1, 1'b1, 64'hFFFF_FFFF_8765_4321, 1'b0};
    vecs[10] = '{5'd9, 1'b0, 64'h55, 1'b0, 2'd0, 1'b0, 3'd0, 64'd0, 1'b0, 0, 1'b0, 1'b0, 64'd0, 1'b0};
    vecs[11] = '{5'd16, 1'b1, 64'd0, 1'b1, 2'd0, 1'b1, 3'd7, 64'hAB00_0000_0000_0000, 1'b0, 0, 1'b1, 1'b1, 64'h0000_0000_0000_00AB, 1'b0};
    vecs[12] = '{5'd17, 1'b1, 64'd0, 1'b1, 2'd2, 1'b0, 3'd2, 64'd0, 1'b0, 0, 1'b0, 1'b0, 64'd0, 1'b1};
    vecs[13] = '{5'd0, 1'b1, 64'd0, 1'b1, 2'd3, 1'b0, 3'd0, 64'h1111, 1'b0, 1, 1'b1, 1'b0, 64'd0, 1'b0};
    vecs[14] = '{5'd18, 1'b1, 64'd0, 1'b1, 2'd3, 1'b0, 3'd3, 64'd0, 1'b0, 0, 1'b0, 1'b0, 64'd0, 1'b1};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_reg_we", 64'(reg_we_o), 64'd0);
    chk("rst_waddr", 64'(reg_waddr_o), 64'd0);
    chk("rst_wdata", reg_wdata_o, 64'd0);
    chk("rst_commit", 64'(commit_o), 64'd0);
    chk("rst_wb_rd", 64'(wb_rd_o), 64'd0);
    chk("rst_exu_ready", 64'(exu_ready_o), 64'd0);
    chk("rst_lsu_rready", 64'(lsu_rready_o), 64'd0);
    chk("rst_busy", 64'(wb_busy_o), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_exu_ready", 64'(exu_ready_o), 64'd1);
    @(posedge clk); #1;

    for (int i = 0; i < 15; i++) run_vec(vecs[i]);
    @(posedge clk); #1;
    @(posedge clk); #1;

    // Back-to-back ALU ops rd=1,2,3 then rd=0, valid held throughout
    exu_valid_i = 1'b1; exu_rd_we_i = 1'b1; exu_is_load_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exu_rd_i = (i == 3) ? 5'd0 : 5'(i + 1);
      exu_result_i = 64'hA000 + 64'(i);
      @(negedge clk);
      chk("b2b_exu_ready", 64'(exu_ready_o), 64'd1);
      @(posedge clk); #1;
      e.we = (i != 3); e.waddr = exu_rd_i; e.wdata = 64'hA000 + 64'(i);
      e.err = 1'b0; e.cyc = cyc;
      sbq.push_back(e);
    end
    exu_valid_i = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;

    // Reset while waiting on memory; a late response must be ignored
    exu_valid_i = 1'b1; exu_rd_i = 5'd20; exu_rd_we_i = 1'b1;
    exu_is_load_i = 1'b1; exu_load_size_i = 2'd3; exu_addr_lo_i = 3'd0;
    @(posedge clk); #1;
    exu_valid_i = 1'b0;
    @(negedge clk);
    chk("rstmid_in_wait", 64'(lsu_rready_o), 64'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid_lsu_rready", 64'(lsu_rready_o), 64'd0);
    chk("rstmid_exu_ready", 64'(exu_ready_o), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rstmid_busy", 64'(wb_busy_o), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    lsu_rvalid_i = 1'b1; lsu_rdata_i = 64'hBAD;
    @(negedge clk);
    chk("late_lsu_rready", 64'(lsu_rready_o), 64'd0);
    chk("late_exu_ready", 64'(exu_ready_o), 64'd1);
    @(posedge clk); #1;
    lsu_rvalid_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("late_busy", 64'(wb_busy_o), 64'd0);
    chk("scoreboard_empty", 64'(sbq.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
